// File: rtl/axi_pkg.sv
// Shared AXI encodings and read-responder state type.
// Used by the read slave and by axi_burst_addr_gen (also shared with the write side).
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_RESP
    } rd_state_e;

    // Largest legal AxSIZE for a bus of dw bits.
    function automatic int max_size(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address calculator plus WRAP legality flag.
// WRAP support is compiled in only when AXI_RD_WRAP_EN is defined.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    len_i,
    input  logic [2:0]    size_i,
    input  logic [1:0]    burst_i,
    output logic [AW-1:0] next_addr_o,
    output logic          wrap_ok_o
);

    logic [AW-1:0] step;
    logic [AW-1:0] size_mask;
    logic [AW-1:0] incr_next;

    assign step      = AW'(1) << size_i;
    assign size_mask = step - AW'(1);
    assign incr_next = (addr_i & ~size_mask) + step;

`ifdef AXI_RD_WRAP_EN
    logic [AW-1:0] wrap_bytes;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] wrap_next;

    assign wrap_bytes = (AW'(len_i) + AW'(1)) << size_i;
    assign wrap_mask  = wrap_bytes - AW'(1);
    assign wrap_next  = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
    assign wrap_ok_o  = (len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) &&
                        ((addr_i & size_mask) == '0);
`else
    logic unused_len;
    assign unused_len = ^len_i;
    assign wrap_ok_o  = 1'b0;
`endif

    always_comb begin
        next_addr_o = addr_i;
        case (burst_i)
            BURST_INCR: next_addr_o = incr_next;
`ifdef AXI_RD_WRAP_EN
            BURST_WRAP: next_addr_o = wrap_next;
`endif
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_read_slave_fsm.sv
// AXI4 read-channel responder: one AR at a time, one memory read per R beat.
// WRAP bursts are honoured only when AXI_RD_WRAP_EN is defined; otherwise they get SLVERR.
module axi_read_slave_fsm
    import axi_pkg::*;
#(
    parameter int IDW = 12,
    parameter int AW  = 32,
    parameter int DW  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDW-1:0] s_axi_arid,
    input  logic [AW-1:0]  s_axi_araddr,
    input  logic [7:0]     s_axi_arlen,
    input  logic [2:0]     s_axi_arsize,
    input  logic [1:0]     s_axi_arburst,
    input  logic           s_axi_arvalid,
    output logic           s_axi_arready,
    output logic [IDW-1:0] s_axi_rid,
    output logic [DW-1:0]  s_axi_rdata,
    output logic [1:0]     s_axi_rresp,
    output logic           s_axi_rlast,
    output logic           s_axi_rvalid,
    input  logic           s_axi_rready,
    output logic           mem_ren,
    output logic [AW-1:0]  mem_raddr,
    input  logic [DW-1:0]  mem_rdata
);

    localparam int            MAXS       = max_size(DW);
    localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << MAXS;

    rd_state_e      state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     len_q, len_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           rlast_q, rlast_d;
    logic           rvalid_q, rvalid_d;

    logic           idle;
    logic [AW-1:0]  gen_addr;
    logic [7:0]     gen_len;
    logic [2:0]     gen_size;
    logic [1:0]     gen_burst;
    logic [AW-1:0]  next_addr;
    logic           wrap_ok;
    logic           ar_err;

    assign idle = (state_q == ST_IDLE);

    // One generator: in IDLE it vets the incoming AR, otherwise it steps the latched burst.
    assign gen_addr  = idle ? s_axi_araddr  : addr_q;
    assign gen_len   = idle ? s_axi_arlen   : len_q;
    assign gen_size  = idle ? s_axi_arsize  : size_q;
    assign gen_burst = idle ? s_axi_arburst : burst_q;

    axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
        .addr_i      (gen_addr),
        .len_i       (gen_len),
        .size_i      (gen_size),
        .burst_i     (gen_burst),
        .next_addr_o (next_addr),
        .wrap_ok_o   (wrap_ok)
    );

    assign ar_err = (int'(s_axi_arsize) > MAXS) ||
                    (s_axi_arburst == 2'b11) ||
                    ((s_axi_arburst == BURST_WRAP) && !wrap_ok);

    assign s_axi_arready = idle && !rst;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rvalid  = rvalid_q;
    assign mem_ren       = (state_q == ST_FETCH);
    assign mem_raddr     = (state_q == ST_FETCH) ? (addr_q & ALIGN_MASK) : '0;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (s_axi_arvalid) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr;
                    len_d   = s_axi_arlen;
                    size_d  = s_axi_arsize;
                    burst_d = s_axi_arburst;
                    cnt_d   = '0;
                    err_d   = ar_err;
                    if (ar_err) begin
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rlast_d  = (s_axi_arlen == 8'd0);
                        rvalid_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d  = mem_rdata;
                rresp_d  = RESP_OKAY;
                rlast_d  = (cnt_q == len_q);
                rvalid_d = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr;
                        if (err_q) begin
                            // Error beats are generated back to back without touching memory.
                            rlast_d = ((cnt_q + 8'd1) == len_q);
                        end else begin
                            rvalid_d = 1'b0;
                            rlast_d  = 1'b0;
                            state_d  = ST_FETCH;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_axi_read_slave_fsm.sv
// Directed scoreboard bench for axi_read_slave_fsm (default parameters, DW=64).
// WRAP expectations follow AXI_RD_WRAP_EN.
module tb_axi_read_slave_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [11:0] s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [63:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [11:0] id;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp_addr_q[$];

    axi_read_slave_fsm dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memf(input logic [31:0] a);
        return {~a, a};
    endfunction

    // 1-cycle-latency memory
    always @(posedge clk) if (mem_ren) mem_rdata <= memf(mem_raddr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ok(input logic [11:0] id, input logic [31:0] a, input logic last);
        beat_t b;
        exp_addr_q.push_back(a);
        b.data = memf(a); b.resp = 2'b00; b.last = last; b.id = id;
        exp_q.push_back(b);
    endtask

    task automatic push_err(input logic [11:0] id, input logic last);
        beat_t b;
        b.data = '0; b.resp = 2'b10; b.last = last; b.id = id;
        exp_q.push_back(b);
    endtask

    task automatic issue_ar(input logic [11:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept_wait", 64'(n < 50), 64'd1);
        @(posedge clk);
    endtask

    // Consume nb beats; optionally hold rready low for stall_n cycles on beat stall_beat.
    task automatic drain(input int nb, input int stall_beat, input int stall_n,
                         input int exp_ren, input bit lat);
        int beat = 0, cyc = 0, st = 0, ren = 0;
        bit seen_ren = 0, seen_rv = 0;
        logic [63:0] hd; logic [1:0] hr; logic hl; logic [11:0] hi;
        beat_t e;
        logic [31:0] ea;
        while (beat < nb && cyc < 400) begin
            @(negedge clk);
            cyc++;
            s_axi_arvalid = 1'b0;
            if (mem_ren) begin
                ren++;
                if (lat && !seen_ren) chk("ren_latency", 64'(cyc), 64'd1);
                seen_ren = 1;
                if (exp_addr_q.size() != 0) begin
                    ea = exp_addr_q.pop_front();
                    chk("mem_raddr", 64'(mem_raddr), 64'(ea));
                end
            end
            if (s_axi_rvalid) begin
                if (lat && !seen_rv) chk("rvalid_latency", 64'(cyc), 64'd3);
                seen_rv = 1;
                if (beat == stall_beat && st < stall_n) begin
                    s_axi_rready = 1'b0;
                    if (st == 0) begin
                        hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast; hi = s_axi_rid;
                    end else begin
                        chk("stall_rdata", s_axi_rdata, hd);
                        chk("stall_rlast", 64'(s_axi_rlast), 64'(hl));
                        chk("stall_rresp", 64'(s_axi_rresp), 64'(hr));
                        chk("stall_rid", 64'(s_axi_rid), 64'(hi));
                    end
                    chk("stall_no_ren", 64'(mem_ren), 64'd0);
                    st++;
                end else begin
                    s_axi_rready = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(beat), 64'(nb));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rresp", 64'(s_axi_rresp), 64'(e.resp));
                        chk("rlast", 64'(s_axi_rlast), 64'(e.last));
                        chk("rid", 64'(s_axi_rid), 64'(e.id));
                    end
                    beat++;
                end
            end else begin
                if (beat == stall_beat && st > 0) chk("stall_rvalid", 64'(s_axi_rvalid), 64'd1);
                s_axi_rready = 1'b1;
            end
        end
        chk("beat_count", 64'(beat), 64'(nb));
        @(posedge clk);
        if (exp_ren >= 0) chk("mem_ren_count", 64'(ren), 64'(exp_ren));
    endtask

    initial begin
        rst = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        chk("rst_rid", 64'(s_axi_rid), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 64'(s_axi_arready), 64'd1);

        // INCR aligned, latency and rlast placement
        push_ok(12'hA5, 32'h100, 1'b0); push_ok(12'hA5, 32'h108, 1'b0);
        push_ok(12'hA5, 32'h110, 1'b0); push_ok(12'hA5, 32'h118, 1'b1);
        issue_ar(12'hA5, 32'h100, 8'd3, 3'd3, 2'b01);
        drain(4, -1, 0, 4, 1'b1);
        @(negedge clk);
        chk("idle_arready", 64'(s_axi_arready), 64'd1);

        // WRAP
`ifdef AXI_RD_WRAP_EN
        push_ok(12'h011, 32'h118, 1'b0); push_ok(12'h011, 32'h100, 1'b0);
        push_ok(12'h011, 32'h108, 1'b0); push_ok(12'h011, 32'h110, 1'b1);
        issue_ar(12'h011, 32'h118, 8'd3, 3'd3, 2'b10);
        drain(4, -1, 0, 4, 1'b0);
`else
        push_err(12'h011, 1'b0); push_err(12'h011, 1'b0);
        push_err(12'h011, 1'b0); push_err(12'h011, 1'b1);
        issue_ar(12'h011, 32'h118, 8'd3, 3'd3, 2'b10);
        drain(4, -1, 0, 0, 1'b0);
`endif

        // FIXED with backpressure on beat 2
        push_ok(12'h022, 32'h40, 1'b0); push_ok(12'h022, 32'h40, 1'b0);
        push_ok(12'h022, 32'h40, 1'b1);
        issue_ar(12'h022, 32'h40, 8'd2, 3'd2, 2'b00);
        drain(3, 1, 5, 3, 1'b0);

        // oversize beat
        push_err(12'h044, 1'b0); push_err(12'h044, 1'b1);
        issue_ar(12'h044, 32'h80, 8'd1, 3'd4, 2'b01);
        drain(2, -1, 0, 0, 1'b0);

        // reserved burst type
        push_err(12'h055, 1'b0); push_err(12'h055, 1'b1);
        issue_ar(12'h055, 32'h80, 8'd1, 3'd3, 2'b11);
        drain(2, -1, 0, 0, 1'b0);

        // unaligned INCR start
        push_ok(12'h066, 32'h100, 1'b0); push_ok(12'h066, 32'h108, 1'b1);
        issue_ar(12'h066, 32'h103, 8'd1, 3'd3, 2'b01);
        drain(2, -1, 0, 2, 1'b0);

        // reset while beat 2 of a len-7 burst is in flight
        for (int i = 0; i < 8; i++) push_ok(12'h033, 32'h200 + 32'(8 * i), i == 7);
        issue_ar(12'h033, 32'h200, 8'd7, 3'd3, 2'b01);
        drain(1, -1, 0, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_arready_low", 64'(s_axi_arready), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        chk("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("midrst_arready", 64'(s_axi_arready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_quiet_rvalid", 64'(s_axi_rvalid), 64'd0);
            chk("midrst_quiet_ren", 64'(mem_ren), 64'd0);
        end
        push_ok(12'h077, 32'h300, 1'b1);
        issue_ar(12'h077, 32'h300, 8'd0, 3'd3, 2'b01);
        drain(1, -1, 0, 1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("tail_rvalid", 64'(s_axi_rvalid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
